imem_port_arbiter: RTL

//  Shares the single read port of instr_mem between two requesters: I-cache line refill
//  (burst, from icache_nway_multiword) and CPU data-side loads hitting the instruction region.

---
 rtl/imem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single instr_mem read port between I-cache line refills (bursts) and CPU data loads.
// Alternating priority when both ask; a granted burst always runs to completion.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_mem_req,
  input  logic [ADDR_WIDTH-1:0] cache_mem_addr,
  input  logic [3:0]            cache_mem_burst_len,
  output logic                  cache_mem_ready,
  output logic [DATA_WIDTH-1:0] cache_mem_data,
  output logic                  cache_mem_valid,
  output logic                  cache_mem_last,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ack,
  output logic                  data_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DATA} state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 1: burst was granted last
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic [3:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  ready_q, ready_d;
  logic                  cvalid_q, cvalid_d;
  logic                  clast_q, clast_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  data_go;

  // A load being acked this cycle still has data_req high; it must not be regranted.
  assign data_go = data_req & ~ack_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    ready_d      = 1'b0;
    cvalid_d     = 1'b0;
    clast_d      = 1'b0;
    cdata_d      = cdata_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cache_mem_req && (!data_go || !last_grant_q)) begin
          state_d      = S_BURST;
          last_grant_d = 1'b1;
          ready_d      = 1'b1;
          base_d       = cache_mem_addr & WORD_MASK;
          beat_cnt_d   = 4'd0;
          if ({1'b0, cache_mem_burst_len} >= 5'(MAX_BURST))
            len_d = 4'(MAX_BURST - 1);
          else
            len_d = cache_mem_burst_len;
        end else if (data_go) begin
          state_d      = S_DATA;
          last_grant_d = 1'b0;
        end
      end
      S_BURST: begin
        cdata_d  = mem_data;
        cvalid_d = 1'b1;
        if (beat_cnt_q == len_q) begin
          clast_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        rdata_d = mem_data;
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      base_q       <= '0;
      ready_q      <= 1'b0;
      cvalid_q     <= 1'b0;
      clast_q      <= 1'b0;
      cdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      ready_q      <= ready_d;
      cvalid_q     <= cvalid_d;
      clast_q      <= clast_d;
      cdata_q      <= cdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

  // Burst addresses wrap at 32 bits; callers are expected to send line-aligned bases.
  always_comb begin
    mem_addr = '0;
    if (!rst) begin
      if (state_q == S_BURST)
        mem_addr = base_q + {{(ADDR_WIDTH-6){1'b0}}, beat_cnt_q, 2'b00};
      else
        mem_addr = data_addr & WORD_MASK;
    end
  end

  assign cache_mem_ready = ready_q;
  assign cache_mem_valid = cvalid_q;
  assign cache_mem_last  = clast_q;
  assign cache_mem_data  = cdata_q;
  assign data_rdata      = rdata_q;
  assign data_ack        = ack_q;
  assign data_stall      = ~rst & data_req & ~ack_q;

endmodule
